// File: rtl/traffic_pkg.sv
// traffic_pkg: light encoding shared between the traffic light controller
// and the traffic sensor model.
//   light_t       2-bit light code
//   LIGHT_GREEN   2'b00
//   LIGHT_YELLOW  2'b01
//   LIGHT_RED     2'b10 (2'b11 is also treated as red)
package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t LIGHT_GREEN  = 2'b00;
  localparam light_t LIGHT_YELLOW = 2'b01;
  localparam light_t LIGHT_RED    = 2'b10;

endpackage

// File: rtl/traffic_sensor_if.sv
// traffic_sensor_if: street-side bundle between the light controller /
// vehicle source and the traffic sensor.
//   master: drives car_a, car_b, SA, SB; observes TA, TB, counts and flags
//   slave : the sensor; consumes arrivals and lights, reports queue state
interface traffic_sensor_if #(
  parameter int unsigned QUEUE_W = 4
);
  import traffic_pkg::*;

  logic               car_a;
  logic               car_b;
  light_t             SA;
  light_t             SB;
  logic               TA;
  logic               TB;
  logic [QUEUE_W-1:0] count_a;
  logic [QUEUE_W-1:0] count_b;
  logic               overflow_a;
  logic               overflow_b;
  logic               conflict;

  modport master (
    output car_a, car_b, SA, SB,
    input  TA, TB, count_a, count_b, overflow_a, overflow_b, conflict
  );

  modport slave (
    input  car_a, car_b, SA, SB,
    output TA, TB, count_a, count_b, overflow_a, overflow_b, conflict
  );

endinterface

// File: rtl/lane_queue.sv
// lane_queue: one street's car queue.
//   clk, reset : clock, async active-high reset
//   car        : one-cycle arrival pulse (held high = one car per cycle)
//   light      : this street's light
//   present    : queue non-empty (combinational from the registered count)
//   count      : cars queued
//   overflow   : sticky, an arrival was dropped at full capacity
module lane_queue
  import traffic_pkg::*;
#(
  parameter int unsigned QUEUE_W       = 4,
  parameter int unsigned DEPART_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               car,
  input  light_t             light,
  output logic               present,
  output logic [QUEUE_W-1:0] count,
  output logic               overflow
);

  localparam int unsigned        TIMER_W    = 8;
  localparam logic [QUEUE_W-1:0] COUNT_MAX  = '1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DEPART_CYCLES - 1);

  logic [TIMER_W-1:0] r_timer;
  logic [QUEUE_W-1:0] r_count;
  logic               r_overflow;
  logic               w_draining;
  logic               w_depart;

  // Draining needs green and a car waiting, so an empty queue never departs.
  assign w_draining = (light == LIGHT_GREEN) && (r_count != '0);
  assign w_depart   = w_draining && (r_timer == TIMER_LAST);

  // Departure timer, queue count and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Leaving green or emptying discards partial progress.
      if (!w_draining || w_depart) r_timer <= '0;
      else                         r_timer <= r_timer + TIMER_W'(1);

      // Arrival and departure together cancel, even at full capacity.
      case ({car, w_depart})
        2'b10: begin
          if (r_count == COUNT_MAX) r_overflow <= 1'b1;
          else                      r_count    <= r_count + QUEUE_W'(1);
        end
        2'b01:   r_count <= r_count - QUEUE_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign present  = (r_count != '0);
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: rtl/traffic_sensor.sv
// traffic_sensor: two street queues feeding the controller's TA/TB inputs,
// plus a sticky flag for an illegal both-green light condition.
//   clk, reset : clock, async active-high reset
//   bus        : traffic_sensor_if.slave (arrivals, lights in; TA/TB,
//                counts, overflow_a/b, conflict out)
module traffic_sensor
  import traffic_pkg::*;
#(
  parameter int unsigned QUEUE_W       = 4,
  parameter int unsigned DEPART_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  traffic_sensor_if.slave  bus
);

  logic r_conflict;

  lane_queue #(
    .QUEUE_W       (QUEUE_W),
    .DEPART_CYCLES (DEPART_CYCLES)
  ) u_lane_a (
    .clk      (clk),
    .reset    (reset),
    .car      (bus.car_a),
    .light    (bus.SA),
    .present  (bus.TA),
    .count    (bus.count_a),
    .overflow (bus.overflow_a)
  );

  lane_queue #(
    .QUEUE_W       (QUEUE_W),
    .DEPART_CYCLES (DEPART_CYCLES)
  ) u_lane_b (
    .clk      (clk),
    .reset    (reset),
    .car      (bus.car_b),
    .light    (bus.SB),
    .present  (bus.TB),
    .count    (bus.count_b),
    .overflow (bus.overflow_b)
  );

  // Both-green is only reported; the lanes keep draining independently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                 r_conflict <= 1'b0;
    else if ((bus.SA == LIGHT_GREEN) && (bus.SB == LIGHT_GREEN)) r_conflict <= 1'b1;
  end

  assign bus.conflict = r_conflict;

endmodule
